in_buffer: RTL and testbench

Per-input-port flit buffer of a mesh router. Accepts flits from the upstream link (neighbour router or local core) with a valid/ready handshake, stores them in a FIFO, and presents the head flit's destination plus precomputed direction-sign bits to the routing block and switch allocator. The head is removed when the allocator grants it (`pop`). One instance per router input port.

---
 rtl/global_params.sv | 30 +++
 rtl/in_buffer_sync_fifo.sv | 77 +++++++
 rtl/in_buffer.sv | 103 ++++++++++
 tb/tb_in_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/global_params.sv
// Shared mesh parameters and flit/buffer-entry types.
// Imported by the router input buffer and its FIFO wrapper.
package global_params;

   localparam int MESH_SIDE = 4;
   localparam int COORD_W   = $clog2(MESH_SIDE);
   localparam int PAYLOAD_W = 16;

   typedef struct packed {
      logic [COORD_W-1:0]   dest_x;
      logic [COORD_W-1:0]   dest_y;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   // Stored entry: flit plus direction signs fixed at write time.
   typedef struct packed {
      logic  s_dx;
      logic  s_dy;
      flit_t flit;
   } buf_entry_t;

   // Unsigned "strictly less than own coordinate" test.
   function automatic logic coord_below(
      input logic [COORD_W-1:0] c,
      input logic [COORD_W-1:0] own
   );
      return c < own;
   endfunction

endpackage

// File: rtl/in_buffer_sync_fifo.sv
// Generic synchronous FIFO with push/pop/count, storage reset to 0.
// Ports: clk, rst, push, pop, wdata, rdata (head), count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   // Full refuses pushes even with a concurrent pop.
   assign push_ok = push && (cnt_q != FULL);
   assign pop_ok  = pop && (cnt_q != '0);

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(
      input logic [PTR_W-1:0] p
   );
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/in_buffer.sv
// Mesh router input-port flit buffer: FIFO of flits with precomputed
// west/south sign bits for the routing block and switch allocator.
// Ports: clk, rst (async, high), in_flit/in_valid/in_ready upstream,
// dest_x/dest_y/s_delta_x/s_delta_y/valid/out_flit head view, pop grant.
// Optional IN_BUFFER_STATS_EN adds flit_cnt and stall_cnt counters.
module in_buffer
   import global_params::*;
#(
   parameter int X_COORD = 0,
   parameter int Y_COORD = 0,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  flit_t              in_flit,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [COORD_W-1:0] dest_x,
   output logic [COORD_W-1:0] dest_y,
   output logic               s_delta_x,
   output logic               s_delta_y,
   output logic               valid,
   output flit_t              out_flit,
`ifdef IN_BUFFER_STATS_EN
   output logic [31:0]        flit_cnt,
   output logic [31:0]        stall_cnt,
`endif
   input  logic               pop
);

   localparam int ENTRY_W = $bits(flit_t) + 2;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam logic [COORD_W-1:0] OWN_X = COORD_W'(X_COORD);
   localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(Y_COORD);

   buf_entry_t       wr_entry;
   buf_entry_t       head;
   logic [CNT_W-1:0] fifo_cnt;
   logic             push_en;
   logic             pop_en;

   assign in_ready = (fifo_cnt != CNT_W'(DEPTH));
   assign valid    = (fifo_cnt != '0);
   assign push_en  = in_valid && in_ready;
   assign pop_en   = pop && valid;

   always_comb begin
      wr_entry      = '0;
      wr_entry.flit = in_flit;
      wr_entry.s_dx = coord_below(in_flit.dest_x, OWN_X);
      wr_entry.s_dy = coord_below(in_flit.dest_y, OWN_Y);
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en),
      .pop   (pop_en),
      .wdata (wr_entry),
      .rdata (head),
      .count (fifo_cnt)
   );

   assign out_flit  = head.flit;
   assign dest_x    = head.flit.dest_x;
   assign dest_y    = head.flit.dest_y;
   assign s_delta_x = head.s_dx;
   assign s_delta_y = head.s_dy;

`ifdef IN_BUFFER_STATS_EN
   logic [31:0] flit_cnt_q, flit_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Both counters saturate rather than wrap.
   always_comb begin
      flit_cnt_d  = flit_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (push_en && (flit_cnt_q != '1)) begin
         flit_cnt_d = flit_cnt_q + 32'd1;
      end
      if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flit_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         flit_cnt_q  <= flit_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign flit_cnt  = flit_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_in_buffer.sv
// Scoreboard bench for in_buffer at router (1,1), depth 4, 4x4 mesh.
// Stimulus pushes expectations; a negedge monitor checks every pop.
module tb_in_buffer;
   import global_params::*;

   typedef struct packed {
      flit_t f;
      logic  sx;
      logic  sy;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   flit_t              in_flit;
   logic               in_valid;
   logic               in_ready;
   logic [COORD_W-1:0] dest_x;
   logic [COORD_W-1:0] dest_y;
   logic               s_delta_x;
   logic               s_delta_y;
   logic               valid;
   flit_t              out_flit;
   logic               pop;
`ifdef IN_BUFFER_STATS_EN
   logic [31:0]        flit_cnt;
   logic [31:0]        stall_cnt;
`endif

   logic cur_sx;
   logic cur_sy;
   int   vectors = 0;
   int   fails   = 0;
   exp_t q[$];
   exp_t e;

   always #5 clk = ~clk;

   in_buffer #(
      .X_COORD (1),
      .Y_COORD (1),
      .DEPTH   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (in_flit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dest_x    (dest_x),
      .dest_y    (dest_y),
      .s_delta_x (s_delta_x),
      .s_delta_y (s_delta_y),
      .valid     (valid),
      .out_flit  (out_flit),
`ifdef IN_BUFFER_STATS_EN
      .flit_cnt  (flit_cnt),
      .stall_cnt (stall_cnt),
`endif
      .pop       (pop)
   );

   task automatic check(
      input string       name,
      input logic [63:0] act,
      input logic [63:0] exp
   );
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare head on every granted pop, then record accepts.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (pop && valid) begin
            if (q.size() == 0) begin
               check("pop_on_empty_scoreboard", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("head",
                     {out_flit, s_delta_x, s_delta_y, dest_x, dest_y},
                     {e.f, e.sx, e.sy, e.f.dest_x, e.f.dest_y});
            end
         end
         if (in_valid && in_ready) begin
            q.push_back('{f: in_flit, sx: cur_sx, sy: cur_sy});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(
      input logic               v,
      input logic [COORD_W-1:0] dx,
      input logic [COORD_W-1:0] dy,
      input logic [15:0]        pl,
      input logic               sx,
      input logic               sy,
      input logic               p
   );
      in_valid = v;
      in_flit  = '{dest_x: dx, dest_y: dy, payload: pl};
      cur_sx   = sx;
      cur_sy   = sy;
      pop      = p;
   endtask

   // Indexed flit; at (1,1) a sign is set only for coordinate 0.
   task automatic drive_idx(
      input logic v,
      input int   i,
      input logic p
   );
      logic [1:0] dx;
      logic [1:0] dy;
      dx = 2'(i % 4);
      dy = 2'((i / 4) % 4);
      set_in(v, dx, dy, 16'(16'h1000 + i),
             dx == 2'd0, dy == 2'd0, p);
      tick();
   endtask

   task automatic idle(input logic p);
      set_in(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b0, p);
      tick();
   endtask

   task automatic drained(input string name);
      check({name, "_q_empty"}, 64'(q.size()), 64'd0);
      check({name, "_valid"}, 64'(valid), 64'd0);
      check({name, "_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      rst = 1'b1;
      set_in(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_dest", {dest_x, dest_y}, 64'd0);
      check("rst_sign", {s_delta_x, s_delta_y}, 64'd0);
      check("rst_flit", 64'(out_flit), 64'd0);
`ifdef IN_BUFFER_STATS_EN
      check("rst_stats", {flit_cnt, stall_cnt}, 64'd0);
`endif

      // Sign bits: (3,0)->x0 y1, (0,2)->x1 y0, (1,1)->x0 y0
      set_in(1'b1, 2'd3, 2'd0, 16'hA001, 1'b0, 1'b1, 1'b0);
      #1 check("valid_before_edge", 64'(valid), 64'd0);
      tick();
      check("valid_after_1", 64'(valid), 64'd1);
      check("sign_30", {s_delta_x, s_delta_y}, 64'b01);
      set_in(1'b1, 2'd0, 2'd2, 16'hA002, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 2'd1, 2'd1, 16'hA003, 1'b0, 1'b0, 1'b0);
      tick();
      repeat (3) idle(1'b1);
      idle(1'b0);
      drained("signs");

      // Fill, hold a refused 5th, full+pop, then accept
      for (int i = 0; i < 4; i++) drive_idx(1'b1, i, 1'b0);
      check("full_ready", 64'(in_ready), 64'd0);
      drive_idx(1'b1, 4, 1'b0);
      drive_idx(1'b1, 4, 1'b0);
      check("full_hold_ready", 64'(in_ready), 64'd0);
      check("full_hold_valid", 64'(valid), 64'd1);
      drive_idx(1'b1, 4, 1'b1);
      check("pop_from_full_ready", 64'(in_ready), 64'd1);
      drive_idx(1'b1, 4, 1'b0);
      check("refill_ready", 64'(in_ready), 64'd0);
      repeat (4) idle(1'b1);
      idle(1'b0);
      drained("fill");

      // Streaming 20 flits, one per cycle
      stalls = 0;
      drive_idx(1'b1, 20, 1'b0);
      for (int i = 21; i < 40; i++) begin
         if (!in_ready || !valid) stalls++;
         drive_idx(1'b1, i, 1'b1);
      end
      idle(1'b1);
      idle(1'b0);
      check("stream_stalls", 64'(stalls), 64'd0);
      drained("stream");

      // Pop while empty must not disturb state
      idle(1'b1);
      idle(1'b1);
      check("empty_pop_valid", 64'(valid), 64'd0);
      check("empty_pop_ready", 64'(in_ready), 64'd1);
      drive_idx(1'b1, 50, 1'b0);
      check("after_empty_pop_valid", 64'(valid), 64'd1);
      idle(1'b1);
      idle(1'b0);
      drained("empty_pop");

      // Reset with 3 flits held
      for (int i = 60; i < 63; i++) drive_idx(1'b1, i, 1'b0);
      idle(1'b0);
      rst = 1'b1;
      #1 check("async_rst_valid", 64'(valid), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("midrst_valid", 64'(valid), 64'd0);
      check("midrst_ready", 64'(in_ready), 64'd1);
      check("midrst_flit", 64'(out_flit), 64'd0);

`ifdef IN_BUFFER_STATS_EN
      // 6 accepted pushes, 3 stalled cycles
      for (int i = 0; i < 4; i++) drive_idx(1'b1, 70 + i, 1'b0);
      for (int i = 0; i < 3; i++) drive_idx(1'b1, 74, 1'b0);
      idle(1'b1);
      idle(1'b1);
      drive_idx(1'b1, 74, 1'b0);
      drive_idx(1'b1, 75, 1'b0);
      idle(1'b0);
      check("flit_cnt", 64'(flit_cnt), 64'd6);
      check("stall_cnt", 64'(stall_cnt), 64'd3);
      repeat (4) idle(1'b1);
      idle(1'b0);
      drained("stats");
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, fails);
      $finish;
   end

endmodule
